// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline.
// It computes the ALU, link, LUI and AUIPC results, resolves branches and jumps,
// and generates load/store addresses. Results are captured into the EX/MEM fields
// this stage owns. It also drives the fetch redirect/flush pulse and publishes
// combinational forwarding and load-use information back to ID.
module ex_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [5:0]  stall_in,
  input  logic [31:0] reg1_in,
  input  logic [31:0] reg2_in,
  input  logic [4:0]  rsd_in,
  input  logic        write_rsd_in,
  input  logic [5:0]  cmdtype_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] imm_in,
  output logic        branch_or_not,
  output logic [31:0] branch_target,
  output logic        fwd_we,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        load_in_ex,
  output logic [4:0]  rsd_to_mem,
  output logic        write_rsd_to_mem,
  output logic [5:0]  cmdtype_to_mem,
  output logic [31:0] result_to_mem,
  output logic [31:0] mem_addr_to_mem,
  output logic [31:0] store_data_to_mem
);

  localparam int XLEN  = 32;
  localparam int CMD_W = 6;

  localparam logic [CMD_W-1:0] C_NOP   = 6'd0;
  localparam logic [CMD_W-1:0] C_LUI   = 6'd1;
  localparam logic [CMD_W-1:0] C_AUIPC = 6'd2;
  localparam logic [CMD_W-1:0] C_JAL   = 6'd3;
  localparam logic [CMD_W-1:0] C_JALR  = 6'd4;
  localparam logic [CMD_W-1:0] C_BEQ   = 6'd5;
  localparam logic [CMD_W-1:0] C_BNE   = 6'd6;
  localparam logic [CMD_W-1:0] C_BLT   = 6'd7;
  localparam logic [CMD_W-1:0] C_BGE   = 6'd8;
  localparam logic [CMD_W-1:0] C_BLTU  = 6'd9;
  localparam logic [CMD_W-1:0] C_BGEU  = 6'd10;
  localparam logic [CMD_W-1:0] C_LB    = 6'd11;
  localparam logic [CMD_W-1:0] C_LH    = 6'd12;
  localparam logic [CMD_W-1:0] C_LW    = 6'd13;
  localparam logic [CMD_W-1:0] C_LBU   = 6'd14;
  localparam logic [CMD_W-1:0] C_LHU   = 6'd15;
  localparam logic [CMD_W-1:0] C_SB    = 6'd16;
  localparam logic [CMD_W-1:0] C_SH    = 6'd17;
  localparam logic [CMD_W-1:0] C_SW    = 6'd18;
  localparam logic [CMD_W-1:0] C_ADDI  = 6'd19;
  localparam logic [CMD_W-1:0] C_SLTI  = 6'd20;
  localparam logic [CMD_W-1:0] C_SLTIU = 6'd21;
  localparam logic [CMD_W-1:0] C_XORI  = 6'd22;
  localparam logic [CMD_W-1:0] C_ORI   = 6'd23;
  localparam logic [CMD_W-1:0] C_ANDI  = 6'd24;
  localparam logic [CMD_W-1:0] C_SLLI  = 6'd25;
  localparam logic [CMD_W-1:0] C_SRLI  = 6'd26;
  localparam logic [CMD_W-1:0] C_SRAI  = 6'd27;
  localparam logic [CMD_W-1:0] C_ADD   = 6'd28;
  localparam logic [CMD_W-1:0] C_SUB   = 6'd29;
  localparam logic [CMD_W-1:0] C_SLL   = 6'd30;
  localparam logic [CMD_W-1:0] C_SLT   = 6'd31;
  localparam logic [CMD_W-1:0] C_SLTU  = 6'd32;
  localparam logic [CMD_W-1:0] C_XOR   = 6'd33;
  localparam logic [CMD_W-1:0] C_OR    = 6'd34;
  localparam logic [CMD_W-1:0] C_AND   = 6'd35;
  localparam logic [CMD_W-1:0] C_SRL   = 6'd36;
  localparam logic [CMD_W-1:0] C_SRA   = 6'd37;

  logic signed [XLEN-1:0] reg1_s, reg2_s, imm_s;
  logic [XLEN-1:0]        sum_imm, pc_imm, pc_plus4;
  logic [4:0]             sh_rs2, sh_imm;
  logic                   lt_rr_s, lt_rr_u, lt_ri_s, lt_ri_u;
  logic                   unused_stall;

  logic [CMD_W-1:0] cmd_p0;
  logic [XLEN-1:0]  result_p0, addr_p0, sdata_p0, target_p0;
  logic             redirect_p0, is_load_p0;

  assign reg1_s   = $signed(reg1_in);
  assign reg2_s   = $signed(reg2_in);
  assign imm_s    = $signed(imm_in);
  assign sum_imm  = reg1_in + imm_in;
  assign pc_imm   = pc_in + imm_in;
  assign pc_plus4 = pc_in + 32'd4;
  assign sh_rs2   = reg2_in[4:0];
  assign sh_imm   = imm_in[4:0];
  assign lt_rr_s  = reg1_s < reg2_s;
  assign lt_rr_u  = reg1_in < reg2_in;
  assign lt_ri_s  = reg1_s < imm_s;
  assign lt_ri_u  = reg1_in < imm_in;
  // Only the EX and MEM stall bits matter here.
  assign unused_stall = ^{stall_in[5], stall_in[2:0]};

  // Decode and evaluate the command presented by ID/EX; unknown codes act as NOP.
  always_comb begin
    cmd_p0      = (cmdtype_in > C_SRA) ? C_NOP : cmdtype_in;
    result_p0   = '0;
    addr_p0     = '0;
    sdata_p0    = '0;
    target_p0   = '0;
    redirect_p0 = 1'b0;
    is_load_p0  = 1'b0;
    case (cmd_p0)
      C_LUI:   result_p0 = imm_in;
      C_AUIPC: result_p0 = pc_imm;
      C_JAL: begin
        result_p0   = pc_plus4;
        target_p0   = pc_imm;
        redirect_p0 = 1'b1;
      end
      C_JALR: begin
        result_p0   = pc_plus4;
        target_p0   = sum_imm & ~32'd1;
        redirect_p0 = 1'b1;
      end
      C_BEQ:  begin target_p0 = pc_imm; redirect_p0 = (reg1_in == reg2_in); end
      C_BNE:  begin target_p0 = pc_imm; redirect_p0 = (reg1_in != reg2_in); end
      C_BLT:  begin target_p0 = pc_imm; redirect_p0 = lt_rr_s;  end
      C_BGE:  begin target_p0 = pc_imm; redirect_p0 = !lt_rr_s; end
      C_BLTU: begin target_p0 = pc_imm; redirect_p0 = lt_rr_u;  end
      C_BGEU: begin target_p0 = pc_imm; redirect_p0 = !lt_rr_u; end
      C_LB, C_LH, C_LW, C_LBU, C_LHU: begin
        addr_p0    = sum_imm;
        is_load_p0 = 1'b1;
      end
      C_SB, C_SH, C_SW: begin
        addr_p0  = sum_imm;
        sdata_p0 = reg2_in;
      end
      C_ADDI:  result_p0 = sum_imm;
      C_SLTI:  result_p0 = {{(XLEN-1){1'b0}}, lt_ri_s};
      C_SLTIU: result_p0 = {{(XLEN-1){1'b0}}, lt_ri_u};
      C_XORI:  result_p0 = reg1_in ^ imm_in;
      C_ORI:   result_p0 = reg1_in | imm_in;
      C_ANDI:  result_p0 = reg1_in & imm_in;
      C_SLLI:  result_p0 = reg1_in << sh_imm;
      C_SRLI:  result_p0 = reg1_in >> sh_imm;
      C_SRAI:  result_p0 = $unsigned(reg1_s >>> sh_imm);
      C_ADD:   result_p0 = reg1_in + reg2_in;
      C_SUB:   result_p0 = reg1_in - reg2_in;
      C_SLL:   result_p0 = reg1_in << sh_rs2;
      C_SLT:   result_p0 = {{(XLEN-1){1'b0}}, lt_rr_s};
      C_SLTU:  result_p0 = {{(XLEN-1){1'b0}}, lt_rr_u};
      C_XOR:   result_p0 = reg1_in ^ reg2_in;
      C_OR:    result_p0 = reg1_in | reg2_in;
      C_AND:   result_p0 = reg1_in & reg2_in;
      C_SRL:   result_p0 = reg1_in >> sh_rs2;
      C_SRA:   result_p0 = $unsigned(reg1_s >>> sh_rs2);
      default: result_p0 = '0;
    endcase
  end

  // Redirect is suppressed whenever EX is not advancing; forwarding excludes loads.
  always_comb begin
    branch_or_not = rdy_in && !stall_in[3] && redirect_p0;
    branch_target = target_p0;
    fwd_we        = write_rsd_in && (rsd_in != 5'd0) && !is_load_p0;
    fwd_rd        = rsd_in;
    fwd_data      = result_p0;
    load_in_ex    = is_load_p0;
  end

  // ---- EX / MEM boundary ----
  // EX/MEM register: hold when not ready, bubble or hold on stall, else capture.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsd_to_mem        <= '0;
      write_rsd_to_mem  <= 1'b0;
      cmdtype_to_mem    <= '0;
      result_to_mem     <= '0;
      mem_addr_to_mem   <= '0;
      store_data_to_mem <= '0;
    end else if (rdy_in) begin
      if (stall_in[3] && !stall_in[4]) begin
        rsd_to_mem        <= '0;
        write_rsd_to_mem  <= 1'b0;
        cmdtype_to_mem    <= '0;
        result_to_mem     <= '0;
        mem_addr_to_mem   <= '0;
        store_data_to_mem <= '0;
      end else if (!stall_in[3]) begin
        rsd_to_mem        <= rsd_in;
        write_rsd_to_mem  <= write_rsd_in;
        cmdtype_to_mem    <= cmd_p0;
        result_to_mem     <= result_p0;
        mem_addr_to_mem   <= addr_p0;
        store_data_to_mem <= sdata_p0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed corner cases followed by randomized commands,
// stalls and ready gaps, all checked against a behavioural model of the stage.
module tb_ex_stage;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, write_rsd_in;
  logic [5:0]  stall_in, cmdtype_in;
  logic [31:0] reg1_in, reg2_in, pc_in, imm_in;
  logic [4:0]  rsd_in;
  logic        branch_or_not, fwd_we, load_in_ex, write_rsd_to_mem;
  logic [31:0] branch_target, fwd_data, result_to_mem, mem_addr_to_mem, store_data_to_mem;
  logic [4:0]  fwd_rd, rsd_to_mem;
  logic [5:0]  cmdtype_to_mem;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the combinational view of the current command
  logic [31:0] e_res, e_addr, e_sd, e_tgt;
  logic        e_redir, e_load;
  logic [5:0]  e_cmd;
  // Model of the EX/MEM register
  logic [4:0]  m_rsd;
  logic        m_we;
  logic [5:0]  m_cmd;
  logic [31:0] m_res, m_addr, m_sd;

  ex_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .reg1_in(reg1_in), .reg2_in(reg2_in), .rsd_in(rsd_in), .write_rsd_in(write_rsd_in),
    .cmdtype_in(cmdtype_in), .pc_in(pc_in), .imm_in(imm_in),
    .branch_or_not(branch_or_not), .branch_target(branch_target),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .load_in_ex(load_in_ex),
    .rsd_to_mem(rsd_to_mem), .write_rsd_to_mem(write_rsd_to_mem),
    .cmdtype_to_mem(cmdtype_to_mem), .result_to_mem(result_to_mem),
    .mem_addr_to_mem(mem_addr_to_mem), .store_data_to_mem(store_data_to_mem)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic string op_name(input int c);
    case (c)
      19, 28: return "add";
      29:     return "sub";
      20, 31: return "slt";
      21, 32: return "sltu";
      22, 33: return "xor";
      23, 34: return "or";
      24, 35: return "and";
      25, 30: return "sll";
      26, 36: return "srl";
      27, 37: return "sra";
      default: return "";
    endcase
  endfunction

  function automatic logic [31:0] alu(input string op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      "add":  return a + b;
      "sub":  return a - b;
      "slt":  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      "sltu": return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      "xor":  return a ^ b;
      "or":   return a | b;
      "and":  return a & b;
      "sll":  return 32'(longint'(a) * (longint'(1) << sh));
      "srl":  return 32'(longint'(a) / (longint'(1) << sh));
      "sra":  return 32'(int'(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Expected combinational behaviour of the command currently on the inputs.
  task automatic predict();
    int c;
    bit taken;
    c = int'(cmdtype_in);
    e_res = 0; e_addr = 0; e_sd = 0; e_tgt = 0; e_redir = 0; e_load = 0;
    e_cmd = (c <= 37) ? cmdtype_in : 6'd0;
    if (c == 1) e_res = imm_in;
    else if (c == 2) e_res = pc_in + imm_in;
    else if (c == 3) begin e_res = pc_in + 4; e_redir = 1; e_tgt = pc_in + imm_in; end
    else if (c == 4) begin e_res = pc_in + 4; e_redir = 1; e_tgt = (reg1_in + imm_in) & 32'hFFFF_FFFE; end
    else if (c >= 5 && c <= 10) begin
      case (c)
        5: taken = (reg1_in == reg2_in);
        6: taken = (reg1_in != reg2_in);
        7: taken = int'(reg1_in) < int'(reg2_in);
        8: taken = int'(reg1_in) >= int'(reg2_in);
        9: taken = longint'(reg1_in) < longint'(reg2_in);
        default: taken = longint'(reg1_in) >= longint'(reg2_in);
      endcase
      e_redir = taken;
      e_tgt = pc_in + imm_in;
    end
    else if (c >= 11 && c <= 15) begin e_addr = reg1_in + imm_in; e_load = 1; end
    else if (c >= 16 && c <= 18) begin e_addr = reg1_in + imm_in; e_sd = reg2_in; end
    else if (c >= 19 && c <= 37) e_res = alu(op_name(c), reg1_in, (c >= 28) ? reg2_in : imm_in);
  endtask

  task automatic model_reset();
    m_rsd = 0; m_we = 0; m_cmd = 0; m_res = 0; m_addr = 0; m_sd = 0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "/rsd"},  32'(rsd_to_mem), 32'(m_rsd));
    check_eq({tag, "/we"},   32'(write_rsd_to_mem), 32'(m_we));
    check_eq({tag, "/cmd"},  32'(cmdtype_to_mem), 32'(m_cmd));
    check_eq({tag, "/res"},  result_to_mem, m_res);
    check_eq({tag, "/addr"}, mem_addr_to_mem, m_addr);
    check_eq({tag, "/sd"},   store_data_to_mem, m_sd);
  endtask

  // Called just after a negedge with inputs driven: checks comb outputs,
  // advances through one posedge, checks the EX/MEM register, returns at negedge.
  task automatic step(input string tag);
    logic exp_bon;
    #1;
    predict();
    exp_bon = rdy_in && !stall_in[3] && e_redir;
    check_eq({tag, "/bon"}, 32'(branch_or_not), 32'(exp_bon));
    if (exp_bon) check_eq({tag, "/tgt"}, branch_target, e_tgt);
    check_eq({tag, "/fwe"}, 32'(fwd_we), 32'(write_rsd_in && rsd_in != 0 && !e_load));
    check_eq({tag, "/frd"}, 32'(fwd_rd), 32'(rsd_in));
    if (!e_load) check_eq({tag, "/fdat"}, fwd_data, e_res);
    check_eq({tag, "/lde"}, 32'(load_in_ex), 32'(e_load));
    if (rdy_in) begin
      if (stall_in[3] && !stall_in[4]) model_reset();
      else if (!stall_in[3]) begin
        m_rsd = rsd_in; m_we = write_rsd_in; m_cmd = e_cmd;
        m_res = e_res; m_addr = e_addr; m_sd = e_sd;
      end
    end
    @(posedge clk_in);
    #1;
    check_regs(tag);
    @(negedge clk_in);
  endtask

  task automatic set_in(input int cmd, input logic [31:0] r1, input logic [31:0] r2,
                        input int rd, input bit we, input logic [31:0] pc, input logic [31:0] imm);
    cmdtype_in = 6'(cmd); reg1_in = r1; reg2_in = r2; rsd_in = 5'(rd);
    write_rsd_in = we; pc_in = pc; imm_in = imm; rdy_in = 1'b1; stall_in = 6'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_in = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk_in);
    check_regs("reset");
    check_eq("reset/bon", 32'(branch_or_not), 32'd0);
    check_eq("reset/fwe", 32'(fwd_we), 32'd0);
    check_eq("reset/fdat", fwd_data, 32'd0);
    rst_in = 1'b0;

    // ADD overflow wraps
    set_in(28, 32'h7FFF_FFFF, 32'd1, 5, 1, 32'h0, 32'h0);
    step("add");
    check_eq("add/const", result_to_mem, 32'h8000_0000);

    // Signed vs unsigned compare on the same operands
    set_in(7, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'h100, 32'hFFFF_FFF8);
    #1;
    check_eq("blt/bon_const", 32'(branch_or_not), 32'd1);
    check_eq("blt/tgt_const", branch_target, 32'h0000_00F8);
    step("blt");
    set_in(9, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'h100, 32'hFFFF_FFF8);
    #1;
    check_eq("bltu/bon_const", 32'(branch_or_not), 32'd0);
    step("bltu");

    // JALR clears bit 0 of the target and links pc+4
    set_in(4, 32'h1003, 32'h0, 1, 1, 32'h40, 32'd4);
    #1;
    check_eq("jalr/tgt_const", branch_target, 32'h1006);
    step("jalr");
    check_eq("jalr/res_const", result_to_mem, 32'h44);

    // Load: no forwarding, load-use flag raised
    set_in(13, 32'h2000, 32'h0, 3, 1, 32'h0, 32'hFFFF_FFFC);
    #1;
    check_eq("lw/lde_const", 32'(load_in_ex), 32'd1);
    check_eq("lw/fwe_const", 32'(fwd_we), 32'd0);
    step("lw");
    check_eq("lw/addr_const", mem_addr_to_mem, 32'h1FFC);

    // Taken BEQ under EX stall only: no pulse, bubble
    set_in(5, 32'h55, 32'h55, 0, 0, 32'h200, 32'h10);
    stall_in = 6'b001000;
    step("beq_stall");
    check_eq("beq_stall/addr_const", mem_addr_to_mem, 32'h0);

    // EX and MEM stalled: hold previous ADD
    set_in(28, 32'h10, 32'h20, 9, 1, 32'h0, 32'h0);
    step("add2");
    set_in(5, 32'h55, 32'h55, 0, 0, 32'h200, 32'h10);
    stall_in = 6'b011000;
    step("beq_hold");
    check_eq("beq_hold/res_const", result_to_mem, 32'h30);
    set_in(5, 32'h55, 32'h55, 0, 0, 32'h200, 32'h10);
    rdy_in = 1'b0;
    step("beq_nordy");
    check_eq("beq_nordy/rsd_const", 32'(rsd_to_mem), 32'd9);

    // Unknown command codes behave as NOP
    set_in(50, 32'h1234, 32'h5678, 7, 1, 32'h300, 32'h4);
    step("badcmd");

    // Randomized commands, stalls and ready gaps
    for (int i = 0; i < 400; i++) begin
      int c;
      logic [31:0] r1;
      c = $urandom_range(0, 45);
      r1 = rand_val();
      set_in(c, r1, ($urandom_range(0, 3) == 0) ? r1 : rand_val(), $urandom_range(0, 31),
             $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, rand_val());
      rdy_in = ($urandom_range(0, 9) != 0);
      stall_in = 6'($urandom);
      stall_in[3] = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // Asynchronous reset mid-cycle while a store sits in EX/MEM
    set_in(18, 32'h3000, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'd8);
    step("sw");
    check_eq("sw/sd_const", store_data_to_mem, 32'hDEAD_BEEF);
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    check_regs("async_rst");
    stall_in = 6'b011000;
    @(posedge clk_in);
    #1;
    check_regs("rst_held");
    @(negedge clk_in);
    rst_in = 1'b0;
    set_in(23, 32'hF0, 32'h0, 4, 1, 32'h0, 32'h0F);
    step("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
